load_store_unit: RTL and testbench

Execute-stage block that consumes `lw`/`sw` decode results and performs the word access to data memory over a request/acknowledge handshake. It computes the effective address, checks alignment, and holds the request until memory responds. Loads return data to the register-file write port and stores report completion. It sits directly downstream of the load/store/shift decoder, between the register-file read ports and the data memory.

---
 rtl/load_store_unit.sv | 135 +++++++++++++
 tb/tb_load_store_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: word load/store execute stage with a req/ack data-memory handshake
//
// Optional feature: define LSU_TIMEOUT_EN to abort a REQ that waits
// TIMEOUT_CYCLES cycles without an ack (bus_error_o pulse, no write-back).
//
// Ports:
//   clk_i, rst_i         clock (rising edge), asynchronous active-high reset
//   valid_i, ready_o     instruction handshake; ready_o is high in IDLE
//   is_load_i/is_store_i decoder flags (both set = load)
//   rs1_data_i           base register, immediate_i sign-extended offset
//   rs2_data_i           store data, rd_i load destination
//   mem_req_o/we/addr/wdata  data-memory request, held stable until ack
//   mem_ack_i/rdata      single-cycle memory response
//   wb_valid_o/rd/data   register-file write-back strobe (suppressed for rd 0)
//   done_o               store-complete pulse
//   misaligned_o         alignment-fault pulse (no memory access)
//   bus_error_o          timeout-abort pulse (0 without LSU_TIMEOUT_EN)
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [31:0] immediate_i,
    input  logic [4:0]  rd_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        done_o,
    output logic        misaligned_o,
    output logic        bus_error_o
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WB} state_t;
    state_t      r_state;
    logic [4:0]  r_rd;
    logic [31:0] w_addr;
    logic        w_accept;
    logic        w_we;
`ifdef LSU_TIMEOUT_EN
    logic [7:0]  r_cnt;
`else
    logic [7:0]  w_unused_timeout;
    assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
    assign bus_error_o = 1'b0;
`endif

    assign ready_o  = (r_state == S_IDLE);
    assign w_addr   = rs1_data_i + immediate_i;
    assign w_accept = valid_i && ready_o && (is_load_i || is_store_i);
    // a simultaneous load flag wins over the store flag
    assign w_we     = is_store_i && !is_load_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_rd         <= '0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            wb_valid_o   <= 1'b0;
            wb_rd_o      <= '0;
            wb_data_o    <= '0;
            done_o       <= 1'b0;
            misaligned_o <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            bus_error_o  <= 1'b0;
            r_cnt        <= '0;
`endif
        end else begin
            wb_valid_o   <= 1'b0;
            done_o       <= 1'b0;
            misaligned_o <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            bus_error_o  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_addr[1:0] != 2'b00) begin
                            misaligned_o <= 1'b1;
                        end else begin
                            r_state     <= S_REQ;
                            r_rd        <= rd_i;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= w_we;
                            mem_addr_o  <= w_addr;
                            mem_wdata_o <= w_we ? rs2_data_i : '0;
`ifdef LSU_TIMEOUT_EN
                            r_cnt       <= '0;
`endif
                        end
                    end
                end
                S_REQ: begin
                    // an ack in the expiry cycle takes priority over the abort
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        if (mem_we_o) begin
                            done_o  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            wb_valid_o <= (r_rd != 5'd0);
                            wb_rd_o    <= r_rd;
                            wb_data_o  <= mem_rdata_i;
                            r_state    <= S_WB;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (r_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        mem_req_o   <= 1'b0;
                        bus_error_o <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
`endif
                end
                S_WB:    r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against a transaction-level model
module tb_load_store_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        is_load_i = 1'b0;
    logic        is_store_i = 1'b0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic [31:0] immediate_i = '0;
    logic [4:0]  rd_i = '0;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        ready_o, mem_req_o, mem_we_o, wb_valid_o, done_o, misaligned_o, bus_error_o;
    logic [31:0] mem_addr_o, mem_wdata_o, wb_data_o;
    logic [4:0]  wb_rd_o;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .is_load_i(is_load_i), .is_store_i(is_store_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .immediate_i(immediate_i), .rd_i(rd_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .done_o(done_o), .misaligned_o(misaligned_o), .bus_error_o(bus_error_o)
    );

    typedef struct {
        logic        misal;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          n_req, n_wb, n_done, n_be, lat;
    } exp_t;

    // Whole-transaction outcome: what is requested, which pulses occur, and when ready returns.
    function automatic exp_t model(input logic ld, input logic st, input logic [31:0] rs1,
                                   input logic [31:0] imm, input logic [31:0] rs2,
                                   input logic [4:0] rd, input int d);
        exp_t e;
        e.addr   = rs1 + imm;
        e.misal  = (e.addr % 4) != 0;
        e.we     = st && !ld;
        e.wdata  = e.we ? rs2 : 32'd0;
        e.n_req  = e.misal ? 0 : d + 1;
        e.n_wb   = (!e.misal && !e.we && rd != 0) ? 1 : 0;
        e.n_done = (!e.misal && e.we) ? 1 : 0;
        e.n_be   = 0;
        e.lat    = e.misal ? 1 : (e.we ? 2 + d : 3 + d);
`ifdef LSU_TIMEOUT_EN
        if (!e.misal && d >= TO) begin
            e.n_req = TO; e.lat = TO + 1; e.n_wb = 0; e.n_done = 0; e.n_be = 1;
        end
`endif
        return e;
    endfunction

    // Issue one access at the current negedge; memory acks on REQ cycle d+1.
    // Returns at the negedge where ready_o is seen again, so calls chain back-to-back.
    task automatic run_txn(input logic ld, input logic st, input logic [31:0] rs1,
                           input logic [31:0] imm, input logic [31:0] rs2,
                           input logic [31:0] rdata, input logic [4:0] rd,
                           input int d, input string name);
        exp_t e;
        int n_req = 0, n_wb = 0, n_done = 0, n_mis = 0, n_be = 0, rc = -1;
        e = model(ld, st, rs1, imm, rs2, rd, d);
        checks++;
        if (ready_o !== 1'b1) begin
            errors++; $display("FAIL %s ready_at_accept got %b exp 1", name, ready_o);
        end
        valid_i = 1'b1; is_load_i = ld; is_store_i = st;
        rs1_data_i = rs1; immediate_i = imm; rs2_data_i = rs2; rd_i = rd;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0; mem_ack_i = 1'b0;
            if (mem_req_o === 1'b1) begin
                n_req++;
                checks++;
                if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {e.we, e.addr, e.wdata}) begin
                    errors++;
                    $display("FAIL %s req_fields got we=%b addr=%h wdata=%h exp we=%b addr=%h wdata=%h",
                             name, mem_we_o, mem_addr_o, mem_wdata_o, e.we, e.addr, e.wdata);
                end
                if (n_req == d + 1) begin
                    mem_ack_i = 1'b1; mem_rdata_i = rdata;
                end
            end
            if (wb_valid_o === 1'b1) begin
                n_wb++;
                checks++;
                if ({wb_rd_o, wb_data_o} !== {rd, rdata} || c != 2 + d) begin
                    errors++;
                    $display("FAIL %s wb_fields got rd=%0d data=%h cycle=%0d exp rd=%0d data=%h cycle=%0d",
                             name, wb_rd_o, wb_data_o, c, rd, rdata, 2 + d);
                end
            end
            if (done_o === 1'b1) n_done++;
            if (misaligned_o === 1'b1) n_mis++;
            if (bus_error_o === 1'b1) n_be++;
            if (ready_o === 1'b1) begin
                rc = c;
                break;
            end
        end
        mem_ack_i = 1'b0;
        checks++;
        if (rc != e.lat) begin
            errors++; $display("FAIL %s ready_cycle got %0d exp %0d", name, rc, e.lat);
        end
        checks++;
        if (n_req != e.n_req) begin
            errors++; $display("FAIL %s req_cycles got %0d exp %0d", name, n_req, e.n_req);
        end
        checks++;
        if (n_wb != e.n_wb) begin
            errors++; $display("FAIL %s wb_pulses got %0d exp %0d", name, n_wb, e.n_wb);
        end
        checks++;
        if (n_done != e.n_done) begin
            errors++; $display("FAIL %s done_pulses got %0d exp %0d", name, n_done, e.n_done);
        end
        checks++;
        if (n_mis != int'(e.misal)) begin
            errors++; $display("FAIL %s misaligned_pulses got %0d exp %0d", name, n_mis, int'(e.misal));
        end
        checks++;
        if (n_be != e.n_be) begin
            errors++; $display("FAIL %s bus_error_pulses got %0d exp %0d", name, n_be, e.n_be);
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        checks++;
        if ({ready_o, mem_req_o, wb_valid_o, done_o, misaligned_o, bus_error_o} !== 6'b100000) begin
            errors++;
            $display("FAIL %s idle got rdy=%b req=%b wb=%b done=%b mis=%b be=%b exp 1 0 0 0 0 0",
                     name, ready_o, mem_req_o, wb_valid_o, done_o, misaligned_o, bus_error_o);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, wb_valid_o, wb_rd_o, wb_data_o,
             done_o, misaligned_o, bus_error_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b we=%b addr=%h wdata=%h wb=%b rd=%0d data=%h done=%b mis=%b be=%b exp all 0",
                     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, wb_valid_o, wb_rd_o, wb_data_o,
                     done_o, misaligned_o, bus_error_o);
        end
        checks++;
        if (ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b exp 1", ready_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic test_directed();
        run_txn(1'b1, 1'b0, 32'h0000_1000, 32'hFFFF_FFFC, 32'h0, 32'hDEAD_BEEF, 5'd5, 1, "aligned_load");
        run_txn(1'b0, 1'b1, 32'h0000_2000, 32'h0000_0008, 32'h1234_5678, 32'h0, 5'd3, 3, "store");
        run_txn(1'b1, 1'b0, 32'h0000_1001, 32'h0, 32'h0, 32'h0, 5'd2, 0, "misaligned");
        run_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 32'hCAFE_F00D, 5'd0, 0, "load_rd0");
        run_txn(1'b1, 1'b1, 32'hFFFF_FFF0, 32'h0000_0020, 32'h5555_AAAA, 32'h0BAD_F00D, 5'd9, 2, "both_flags_wrap");
        check_idle("directed_end");
    endtask

    task automatic test_ignored();
        valid_i = 1'b1; is_load_i = 1'b0; is_store_i = 1'b0;
        rs1_data_i = 32'h0000_1001; immediate_i = '0; mem_ack_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0; mem_ack_i = 1'b0;
        checks++;
        if ({ready_o, mem_req_o, misaligned_o, wb_valid_o, done_o} !== 5'b10000) begin
            errors++;
            $display("FAIL ignored got rdy=%b req=%b mis=%b wb=%b done=%b exp 1 0 0 0 0",
                     ready_o, mem_req_o, misaligned_o, wb_valid_o, done_o);
        end
        check_idle("ignored_after");
    endtask

    task automatic test_back_to_back();
        logic [31:0] rs1, imm;
        logic [1:0]  f;
        logic [4:0]  rd;
        for (int i = 0; i < 40; i++) begin
            rs1 = $urandom;
            imm = $urandom;
            if ($urandom_range(0, 3) != 0) imm = imm - ((rs1 + imm) & 32'h3);
            f  = 2'($urandom_range(1, 3));
            rd = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) rd = 5'd0;
            run_txn(f[0], f[1], rs1, imm, $urandom, $urandom, rd, $urandom_range(0, 3), "random");
        end
        check_idle("random_end");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        valid_i = 1'b1; is_load_i = 1'b1; is_store_i = 1'b0;
        rs1_data_i = 32'h0000_0100; immediate_i = '0; rd_i = 5'd7;
        @(negedge clk);
        valid_i = 1'b0; is_load_i = 1'b0;
        checks++;
        if (mem_req_o !== 1'b1) begin
            errors++; $display("FAIL reset_mid_req_before got %b exp 1", mem_req_o);
        end
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if ({mem_req_o, ready_o} !== 2'b01) begin
            errors++; $display("FAIL reset_mid_async got req=%b rdy=%b exp 0 1", mem_req_o, ready_o);
        end
        @(negedge clk);
        rst_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h7777_7777;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            mem_ack_i = 1'b0;
            if (wb_valid_o !== 1'b0 || done_o !== 1'b0 || mem_req_o !== 1'b0 || ready_o !== 1'b1) n++;
        end
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL reset_mid_after bad_cycles got %0d exp 0", n);
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        run_txn(1'b1, 1'b0, 32'h0000_3000, 32'h4, 32'h0, 32'h1111_2222, 5'd4, 99, "timeout_load");
        run_txn(1'b0, 1'b1, 32'h0000_3000, 32'h8, 32'hABCD_0123, 32'h0, 5'd0, 99, "timeout_store");
        run_txn(1'b1, 1'b0, 32'h0000_3000, 32'hC, 32'h0, 32'h3333_4444, 5'd6, TO - 1, "ack_at_expiry_load");
        run_txn(1'b0, 1'b1, 32'h0000_3000, 32'h0, 32'h9999_0000, 32'h0, 5'd0, TO - 1, "ack_at_expiry_store");
        check_idle("timeout_end");
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
